max_pool_unit: RTL and testbench

//   Streaming 2x2, stride-2 max-pooling stage of the CNN datapath. Consumes one
//   8-bit signed pixel per valid cycle in raster order (IMG_W x IMG_H) and

---
 rtl/max_pool_unit_pkg.sv | 14 +
 rtl/max_pool_unit_signed_max2.sv | 13 +
 rtl/max_pool_unit.sv | 110 +++++++++++
 tb/tb_max_pool_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/max_pool_unit_pkg.sv
// Shared pixel type and helpers for the 2x2 stride-2 max-pooling stage.
// The MAX_POOL_RELU_EN macro enables the fused ReLU clamp in max_pool_unit.
package max_pool_unit_pkg;

    localparam int DATA_W = 8;

    typedef logic signed [DATA_W-1:0] pixel_t;

    // Negative values clamp to zero; non-negative values pass bit-exactly.
    function automatic pixel_t relu(input pixel_t p);
        return p[DATA_W-1] ? '0 : p;
    endfunction

endpackage

// File: rtl/max_pool_unit_signed_max2.sv
// Combinational two-input signed maximum; the output is always one of the
// inputs bit-exactly, so no widening or rounding is involved.
module signed_max2
    import max_pool_unit_pkg::*;
(
    input  pixel_t a,
    input  pixel_t b,
    output pixel_t y
);

    assign y = ($signed(a) >= $signed(b)) ? a : b;

endmodule

// File: rtl/max_pool_unit.sv
// Streaming 2x2 stride-2 max pool over a raster-order IMG_W x IMG_H frame.
// Optional fused ReLU on the pooled result when MAX_POOL_RELU_EN is defined.
module max_pool_unit
    import max_pool_unit_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid
);

    localparam int HALF_W = IMG_W / 2;
    localparam int COL_W  = (IMG_W > 2)  ? $clog2(IMG_W)  : 1;
    localparam int ROW_W  = (IMG_H > 2)  ? $clog2(IMG_H)  : 1;
    localparam int IDX_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    pixel_t           pair_q, pair_d;
    pixel_t           line_buf_q [HALF_W];
    pixel_t           line_buf_d [HALF_W];
    pixel_t           out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;

    logic [IDX_W-1:0] buf_idx;
    pixel_t           in_pix;
    pixel_t           horiz_max;
    pixel_t           pool_max;
    pixel_t           pool_res;

    assign in_pix  = pixel_t'(in_data);
    assign buf_idx = IDX_W'(col_q >> 1);

    signed_max2 u_horiz_max (
        .a (pair_q),
        .b (in_pix),
        .y (horiz_max)
    );

    signed_max2 u_vert_max (
        .a (line_buf_q[buf_idx]),
        .b (horiz_max),
        .y (pool_max)
    );

`ifdef MAX_POOL_RELU_EN
    assign pool_res = relu(pool_max);
`else
    assign pool_res = pool_max;
`endif

    // Even rows fold each horizontal pair into the line buffer; odd rows
    // combine with it and emit one pooled pixel on every odd column.
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        pair_d      = pair_q;
        line_buf_d  = line_buf_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;

        if (in_valid) begin
            if (col_q == COL_W'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_q == ROW_W'(IMG_H - 1)) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end

            if (!col_q[0]) begin
                pair_d = in_pix;
            end else if (!row_q[0]) begin
                line_buf_d[buf_idx] = horiz_max;
            end else begin
                out_data_d  = pool_res;
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            pair_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            pair_q      <= pair_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Line buffer is always rewritten on an even row before being read.
    always_ff @(posedge clk) begin
        line_buf_q <= line_buf_d;
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_max_pool_unit.sv
// Scoreboard testbench for max_pool_unit: a frame-level reference model pushes
// expected pooled pixels with their due cycle; a monitor pops and compares.
module tb_max_pool_unit;

   localparam int IMG_W = 28;
   localparam int IMG_H = 28;
   localparam int NPIX  = IMG_W * IMG_H;
   localparam int NWIN  = (IMG_W / 2) * (IMG_H / 2);

   typedef struct {
      logic [7:0] data;
      int         due;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic [7:0] out_data;
   logic       out_valid;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   exp_t       sb[$];
   logic [7:0] obs[$];
   logic [7:0] obs_prev[$];
   logic [7:0] frame_px [NPIX];
   logic [7:0] ref_pix [IMG_H][IMG_W];
   int         model_k = 0;
   logic       prev_valid = 1'b0;

   max_pool_unit #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .out_data  (out_data),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Reference model: keeps the whole frame and takes the max of each
   // completed 2x2 window once its bottom-right pixel arrives.
   task automatic modelAccept(input logic [7:0] d);
      int r;
      int c;
      logic signed [7:0] m;
      r = model_k / IMG_W;
      c = model_k % IMG_W;
      ref_pix[r][c] = d;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
         m = ref_pix[r][c];
         for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
               if ($signed(ref_pix[r-dr][c-dc]) > m) m = ref_pix[r-dr][c-dc];
`ifdef MAX_POOL_RELU_EN
         if (m < 0) m = 8'sd0;
`endif
         sb.push_back('{data: m, due: cyc + 1});
      end
      model_k = (model_k + 1) % NPIX;
   endtask

   task automatic sendPixel(input logic [7:0] d, input bit v);
      @(posedge clk);
      #1;
      in_data  = d;
      in_valid = v;
      if (v) modelAccept(d);
   endtask

   // Streams the first n pixels of frame_px, optionally with random idle gaps.
   task automatic applyStimulus(input int n, input int gap_pct);
      for (int i = 0; i < n; i++) begin
         while ($urandom_range(99) < gap_pct) sendPixel(8'($urandom), 1'b0);
         sendPixel(frame_px[i], 1'b1);
      end
      repeat (3) sendPixel(8'h00, 1'b0);
   endtask

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic checkCount(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [7:0] obsAt(input int i);
      if (i < obs.size()) return obs[i];
      return 8'bx;
   endfunction

   task automatic pulseReset();
      rst_n = 1'b0;
      #1;
      checkOutput("reset_out_valid", {7'b0, out_valid}, 8'h00);
      checkOutput("reset_out_data", out_data, 8'h00);
      model_k = 0;
      sb.delete();
      #19;
      rst_n = 1'b1;
   endtask

   // Monitor: every pulse must match the head of the scoreboard on its due
   // cycle, be a single cycle wide, and no due entry may be skipped.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid === 1'b1) begin
            checks++;
            if (prev_valid) begin
               errors++;
               $display("[TB] FAIL pulse_width: out_valid high on consecutive cycles at cycle %0d", cyc);
            end
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_pulse: got data %h, expected no pulse", out_data);
            end else begin
               exp_t e;
               e = sb.pop_front();
               checks++;
               if (out_data !== e.data || e.due != cyc) begin
                  errors++;
                  $display("[TB] FAIL pooled_pixel: got %h at cycle %0d, expected %h at cycle %0d",
                           out_data, cyc, e.data, e.due);
               end
            end
            obs.push_back(out_data);
         end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            checks++;
            errors++;
            $display("[TB] FAIL missing_pulse: got out_valid=%b at cycle %0d, expected data %h",
                     out_valid, cyc, sb[0].data);
            void'(sb.pop_front());
         end
         prev_valid = (out_valid === 1'b1);
      end else begin
         prev_valid = 1'b0;
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      #2;
      pulseReset();

      // Ramp frame: known pooled values, including the signed 127/128 window.
      for (int i = 0; i < NPIX; i++) frame_px[i] = 8'(i % 256);
      obs.delete();
      applyStimulus(NPIX, 0);
      checkCount("ramp_pulse_count", obs.size(), NWIN);
      checkOutput("ramp_out0", obsAt(0), 8'd29);
      checkOutput("ramp_out1", obsAt(1), 8'd31);
      checkOutput("ramp_signed_wrap", obsAt(35), 8'd127);

      // All-negative top-left window.
      for (int i = 0; i < NPIX; i++) frame_px[i] = 8'($urandom);
      frame_px[0]     = 8'h80;
      frame_px[1]     = 8'hFF;
      frame_px[IMG_W] = 8'hFB;
      frame_px[IMG_W+1] = 8'h9C;
      obs.delete();
      applyStimulus(NPIX, 0);
      checkCount("neg_window_count", obs.size(), NWIN);
`ifdef MAX_POOL_RELU_EN
      checkOutput("neg_window", obsAt(0), 8'h00);
`else
      checkOutput("neg_window", obsAt(0), 8'hFF);
`endif

      // Random frame, continuous, then the same frame with random gaps.
      for (int i = 0; i < NPIX; i++) frame_px[i] = 8'($urandom);
      obs.delete();
      applyStimulus(NPIX, 0);
      checkCount("random_pulse_count", obs.size(), NWIN);
      obs_prev = obs;
      obs.delete();
      applyStimulus(NPIX, 30);
      checkCount("gap_pulse_count", obs.size(), NWIN);
      for (int i = 0; i < NWIN && i < obs_prev.size(); i++)
         checkOutput("gap_sequence", obsAt(i), obs_prev[i]);

      // Reset mid-frame then a full ramp frame: no stale window may appear.
      for (int i = 0; i < NPIX; i++) frame_px[i] = 8'(i % 256);
      applyStimulus(300, 0);
      @(posedge clk);
      #1;
      pulseReset();
      obs.delete();
      applyStimulus(NPIX, 0);
      checkCount("post_reset_count", obs.size(), NWIN);
      checkOutput("post_reset_out0", obsAt(0), 8'd29);
      checkCount("scoreboard_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
